router_rr_controller: RTL and testbench
=======================================

Name: router_rr_controller

Overview:
- Moore-FSM controller and round-robin arbiter for the 4-port 8-bit router datapath.
- Grants one of four requesters the shared input bus and sequences each packet through the datapath: store, wait for acknowledged, forward, wait for received.
- Replaces fixed-priority sequencing with fair arbitration and adds a handshake timeout so a stalled transfer cannot hang the router.

Parameters:
- TIMEOUT, 16, max cycles spent in WAIT_ACK or WAIT_RCV before abort (legal range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- request  input  4  request[i] = port i+1 requesting the bus; level-sensitive.
- acknowledged  input  1  datapath has latched the stored byte.
- received  input  1  datapath output port has accepted the forwarded byte.
- hdr_dest  input  2  destination port index decoded by the datapath from the latched byte; valid while acknowledged=1.
- on_bus  output  4  one-hot grant; drives dp1..dp4_on_bus.
- st_router  output  1  store strobe to datapath.
- fw_router  output  1  forward strobe to datapath.
- in_addr  output  4  one-hot source select (equals on_bus while granted).
- out_addr  output  4  one-hot destination select.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  one-cycle pulse when a transfer is aborted.

Behaviour:
- All outputs registered. rst=0 asynchronously forces state=IDLE and all outputs to 0, ptr=3, timer=0.
- ptr holds the index of the last granted port. Search order is ptr+1, ptr+2, ... modulo 4. After reset, port 0 (request1) has highest priority.
- IDLE: if request!=0, latch the winner g and go to STORE. The next cycle has on_bus=in_addr=onehot(g), busy=1. If request=0, stay in IDLE.
- STORE: st_router=1 for exactly one cycle. Go to WAIT_ACK. Clear timer.
- WAIT_ACK: on acknowledged=1, register d=hdr_dest and go to FORWARD. Otherwise timer++. When timer reaches TIMEOUT-1 with no ack, go to ABORT.
- FORWARD: fw_router=1 for one cycle, out_addr=onehot(d). Go to WAIT_RCV. Clear timer.
- WAIT_RCV: out_addr held. On received=1, go to RELEASE. Same timeout rule as WAIT_ACK, going to ABORT.
- RELEASE: on_bus, in_addr, out_addr cleared. ptr=g. Go to IDLE.
- ABORT: timeout_err=1 for one cycle. Selects cleared. ptr=g, so the stalled port loses priority. Go to IDLE.
- Best-case latency from request rising in IDLE to on_bus: 1 cycle. Minimum transaction with ack and received each one cycle after the strobe: IDLE→STORE→WAIT_ACK→FORWARD→WAIT_RCV→RELEASE→IDLE.
- Back-to-back: at least one IDLE cycle between grants. No grant is issued in RELEASE or ABORT.
- Request withdrawn mid-transaction: ignored; the transaction runs to completion or timeout.
- acknowledged or received outside its wait state: ignored.
- Simultaneous acknowledged and timer expiry in the same cycle: acknowledged wins. The same applies to received.
- hdr_dest equal to the source port: legal; forwarded normally.
- st_router and fw_router are never high together. on_bus is always one-hot or zero.
- Illegal or unused state encodings recover to IDLE with outputs cleared.

Test Plan:
- Reset mid-transaction: assert rst=0 during FORWARD → all outputs 0 immediately without waiting for clk. After release, request=4'b0010 grants on_bus=4'b0010 one cycle later.
- Single port 3, request=4'b0100, ack 1 cycle after st_router, hdr_dest=2'd0, received 1 cycle after fw_router → on_bus=4'b0100, one st_router pulse, one fw_router pulse, out_addr=4'b0001, back to IDLE in 6 cycles, busy low afterwards.
- Fairness: request=4'b1111 held for 4 transactions → grant order port1, port2, port3, port4, then port1 again.
- Ack timeout with TIMEOUT=16: request=4'b0001, acknowledged never asserted → timeout_err pulses exactly once, 16 cycles after leaving STORE. Next grant with request=4'b0011 goes to port 2.
- Receive timeout boundary: received asserted in the same cycle the timer expires → normal RELEASE and no timeout_err. Repeat with received one cycle later → timeout_err=1.
- Withdrawn request: request1 dropped in WAIT_ACK → transaction completes normally. Spurious received during WAIT_ACK → no state change.

Source files
------------

// File: rtl/router_rr_controller.sv
// Round-robin arbiter and Moore sequencer for the 4-port 8-bit router datapath.
// A granted packet is sequenced as: store strobe, wait for the datapath to
// acknowledge the latch, forward strobe, then wait for the output port to
// take the byte. Both waits are bounded by TIMEOUT, so a stalled transfer is
// aborted instead of hanging the router.
//
// Handshake: acknowledged and received are single-cycle level qualifiers.
// Each one is sampled only in its own wait state and ignored everywhere
// else. A qualifier seen in the final timer cycle still completes the
// transfer. All outputs are registered, decoded from the next state.
module router_rr_controller #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] request,
  input  logic       acknowledged,
  input  logic       received,
  input  logic [1:0] hdr_dest,
  output logic [3:0] on_bus,
  output logic       st_router,
  output logic       fw_router,
  output logic [3:0] in_addr,
  output logic [3:0] out_addr,
  output logic       busy,
  output logic       timeout_err,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STORE    = 3'd1,
    WAIT_ACK = 3'd2,
    FORWARD  = 3'd3,
    WAIT_RCV = 3'd4,
    RELEASE  = 3'd5,
    ABORT    = 3'd6
  } state_t;

  // Last timer value allowed in a wait state before the transfer is aborted.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] dest_q, dest_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;

  logic [3:0] on_bus_d, out_addr_d;
  logic       st_d, fw_d, busy_d, terr_d;

  assign fsm_state = state_q;

  // Round-robin search: start one past the last granted port and wrap.
  always_comb begin
    winner = ptr_q + 2'd1;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && request[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state, grant, destination, pointer and wait-timer logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    dest_d  = dest_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (|request) begin
          grant_d = winner;
          state_d = STORE;
        end
      end
      STORE: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (acknowledged) begin
          dest_d  = hdr_dest;
          state_d = FORWARD;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ABORT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      FORWARD: begin
        timer_d = '0;
        state_d = WAIT_RCV;
      end
      WAIT_RCV: begin
        if (received) begin
          state_d = RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ABORT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      // The port just served, or the one that stalled, drops to lowest priority.
      RELEASE, ABORT: begin
        ptr_d   = grant_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    on_bus_d   = '0;
    out_addr_d = '0;
    st_d       = 1'b0;
    fw_d       = 1'b0;
    busy_d     = 1'b0;
    terr_d     = 1'b0;
    case (state_d)
      STORE: begin
        on_bus_d = 4'b0001 << grant_d;
        st_d     = 1'b1;
        busy_d   = 1'b1;
      end
      WAIT_ACK: begin
        on_bus_d = 4'b0001 << grant_d;
        busy_d   = 1'b1;
      end
      FORWARD: begin
        on_bus_d   = 4'b0001 << grant_d;
        out_addr_d = 4'b0001 << dest_d;
        fw_d       = 1'b1;
        busy_d     = 1'b1;
      end
      WAIT_RCV: begin
        on_bus_d   = 4'b0001 << grant_d;
        out_addr_d = 4'b0001 << dest_d;
        busy_d     = 1'b1;
      end
      RELEASE: begin
        busy_d = 1'b1;
      end
      ABORT: begin
        busy_d = 1'b1;
        terr_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, bookkeeping and output registers; the reset puts priority on port 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      dest_q      <= '0;
      ptr_q       <= 2'd3;
      timer_q     <= '0;
      on_bus      <= '0;
      in_addr     <= '0;
      out_addr    <= '0;
      st_router   <= 1'b0;
      fw_router   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      dest_q      <= dest_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      on_bus      <= on_bus_d;
      in_addr     <= on_bus_d;
      out_addr    <= out_addr_d;
      st_router   <= st_d;
      fw_router   <= fw_d;
      busy        <= busy_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_router_rr_controller.sv
// Bench for router_rr_controller. The driver pushes the expected event
// sequence for each transfer before playing it. A negedge monitor turns DUT
// outputs into events and pops and compares them.
// Event record: {kind, on_bus, in_addr, out_addr, gap}.
// kind 1 = store strobe; gap = cycles spent idle with a request pending.
// kind 2 = forward strobe; kind 3 = release; kind 4 = abort;
// kind 5 = return to idle. For kinds 2..5, gap = cycles since the previous event.
module tb_router_rr_controller;

  localparam int TOUT = 16;
  localparam int W    = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] request;
  logic       acknowledged;
  logic       received;
  logic [1:0] hdr_dest;
  logic [3:0] on_bus;
  logic       st_router;
  logic       fw_router;
  logic [3:0] in_addr;
  logic [3:0] out_addr;
  logic       busy;
  logic       timeout_err;
  logic [2:0] fsm_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_evt = 0;
  int lat = 0;
  logic prev_busy = 1'b0;

  // Clock and DUT.
  always #5 clk = ~clk;

  router_rr_controller #(.TIMEOUT(TOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .request      (request),
    .acknowledged (acknowledged),
    .received     (received),
    .hdr_dest     (hdr_dest),
    .on_bus       (on_bus),
    .st_router    (st_router),
    .fw_router    (fw_router),
    .in_addr      (in_addr),
    .out_addr     (out_addr),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .fsm_state    (fsm_state)
  );

  function automatic logic [W-1:0] mk(input logic [3:0] kind, input logic [3:0] ob,
                                      input logic [3:0] ia, input logic [3:0] oa, input int gap);
    return {kind, ob, ia, oa, 8'(gap)};
  endfunction

  // Monitor: invariants every cycle, then event extraction and scoreboard pop.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    logic [3:0]   kind;
    logic [7:0]   gap;
    if (!rst) begin
      prev_busy = 1'b0;
      lat       = 0;
      cyc       = 0;
      last_evt  = 0;
    end else begin
      cyc++;
      checks++;
      if ((st_router && fw_router) || !$onehot0(on_bus) || (in_addr != on_bus)) begin
        errors++;
        $display("FAIL invariant st=%b fw=%b on_bus=%b in_addr=%b required exclusive strobes, one-hot on_bus, in_addr==on_bus",
                 st_router, fw_router, on_bus, in_addr);
      end
      kind = 4'd0;
      if (st_router)                   kind = 4'd1;
      else if (fw_router)              kind = 4'd2;
      else if (timeout_err)            kind = 4'd4;
      else if (busy && on_bus == 4'b0) kind = 4'd3;
      else if (!busy && prev_busy)     kind = 4'd5;
      if (kind != 4'd0) begin
        gap = (kind == 4'd1) ? 8'(lat) : 8'(cyc - last_evt);
        got = {kind, on_bus, in_addr, out_addr, gap};
        last_evt = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event unexpected got=%h required no event", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL event got=%h required=%h", got, exp);
          end
        end
      end
      if (!busy && request != 4'b0) lat++;
      else lat = 0;
      prev_busy = busy;
    end
  end

  // Driver: wait (bounded) for the store strobe.
  task automatic wait_store(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (st_router) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL store_wait got no st_router required one within 40 cycles");
    end
  endtask

  // Driver: one full transfer. ack_wait/rcv_wait give the wait-state cycle
  // (0 = first) in which the qualifier is raised; out of range means never
  // inside the window.
  task automatic txn(input logic [3:0] req, input int g, input int d, input int ack_wait,
                     input int rcv_wait, input bit hold, input bit spur);
    logic [3:0] g1h;
    logic [3:0] d1h;
    bit acked;
    bit ok;
    g1h   = 4'b0001 << g;
    d1h   = 4'b0001 << d;
    acked = (ack_wait >= 0 && ack_wait < TOUT);
    exp_q.push_back(mk(4'd1, g1h, g1h, 4'b0, 1));
    if (acked) begin
      exp_q.push_back(mk(4'd2, g1h, g1h, d1h, 2 + ack_wait));
      if (rcv_wait >= 0 && rcv_wait < TOUT) exp_q.push_back(mk(4'd3, 4'b0, 4'b0, 4'b0, 2 + rcv_wait));
      else                                  exp_q.push_back(mk(4'd4, 4'b0, 4'b0, 4'b0, TOUT + 1));
    end else begin
      exp_q.push_back(mk(4'd4, 4'b0, 4'b0, 4'b0, TOUT + 1));
    end
    exp_q.push_back(mk(4'd5, 4'b0, 4'b0, 4'b0, 1));
    request = req;
    wait_store(ok);
    if (!ok) begin
      request = 4'b0;
      return;
    end
    for (int k = 0; k < TOUT; k++) begin
      @(posedge clk); #1;
      received = spur && (k == 0);
      if (k == 0 && !hold) request = 4'b0;
      if (k == ack_wait) begin
        acknowledged = 1'b1;
        hdr_dest     = 2'(d);
        break;
      end
    end
    @(posedge clk); #1;
    acknowledged = 1'b0;
    received     = 1'b0;
    if (acked) begin
      for (int k = 0; k <= TOUT; k++) begin
        @(posedge clk); #1;
        if (k == rcv_wait) begin
          received = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
      received = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_wait got busy=1 required busy=0 within 8 cycles");
    end
  endtask

  // Driver: all outputs must read zero (used while reset is held).
  task automatic check_zero(input string name);
    logic [18:0] outs;
    outs = {on_bus, in_addr, out_addr, st_router, fw_router, busy, timeout_err, fsm_state};
    checks++;
    if (outs !== 19'b0) begin
      errors++;
      $display("FAIL %s got outputs=%h required 0", name, outs);
    end
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200us");
    $fatal(1, "watchdog");
  end

  // Stimulus sequence.
  initial begin
    bit ok;
    rst          = 1'b0;
    request      = 4'b0;
    acknowledged = 1'b0;
    received     = 1'b0;
    hdr_dest     = 2'd0;
    #1;
    check_zero("reset_state");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Fairness with all ports requesting: 0,1,2,3 then 0 again.
    txn(4'b1111, 0, 1, 0, 0, 1'b1, 1'b0);
    txn(4'b1111, 1, 2, 0, 0, 1'b1, 1'b0);
    txn(4'b1111, 2, 3, 0, 0, 1'b1, 1'b0);
    txn(4'b1111, 3, 0, 0, 0, 1'b1, 1'b0);
    txn(4'b1111, 0, 0, 0, 0, 1'b0, 1'b0);
    // Single port 3 to destination port 1.
    txn(4'b0100, 2, 0, 0, 0, 1'b0, 1'b0);
    // Acknowledge timeout, then the stalled port loses to port 2.
    txn(4'b0001, 0, 0, -1, 0, 1'b0, 1'b0);
    txn(4'b0011, 1, 2, 0, 0, 1'b0, 1'b0);
    // Receive on the last timer cycle completes; one cycle later aborts.
    txn(4'b1000, 3, 1, 0, TOUT - 1, 1'b0, 1'b0);
    txn(4'b1000, 3, 1, 0, TOUT, 1'b0, 1'b0);
    // Acknowledge on the last timer cycle, destination equals source.
    txn(4'b0010, 1, 1, TOUT - 1, 0, 1'b0, 1'b0);
    // Request withdrawn in WAIT_ACK plus a spurious received there.
    txn(4'b0001, 0, 2, 2, 1, 1'b0, 1'b1);
    // Two requesters after port 0 was served: port 3 wins.
    txn(4'b0101, 2, 1, 1, 2, 1'b0, 1'b0);

    // Reset asserted during FORWARD clears outputs without a clock edge.
    exp_q.push_back(mk(4'd1, 4'b1000, 4'b1000, 4'b0, 1));
    request = 4'b1000;
    wait_store(ok);
    @(posedge clk); #1;
    acknowledged = 1'b1;
    hdr_dest     = 2'd1;
    request      = 4'b0;
    @(posedge clk); #1;
    acknowledged = 1'b0;
    checks++;
    if (fw_router !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_forward got fw_router=%b required 1", fw_router);
    end
    rst = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(4'b0010, 1, 3, 0, 0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending events required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
